// File: rtl/expr_pkg.sv
// Shared types and constants for the expression stream arbiter and its checker.
package expr_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        OPND  = 2'd1,
        OPER  = 2'd2,
        ERR   = 2'd3
    } chk_state_t;

    typedef enum logic [1:0] {
        CTL_IDLE   = 2'd0,
        CTL_STREAM = 2'd1,
        CTL_RESULT = 2'd2
    } ctl_state_t;

    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_ADD = 8'h2B;

    function automatic logic is_op(input logic [7:0] b);
        return (b == OP_MUL) || (b == OP_ADD);
    endfunction

endpackage

// File: rtl/expr_checker.sv
// Operand/operator recognizer: accepts operand (operator operand)* one byte per enabled cycle.
module expr_checker
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] in,
    output logic       match
);

    chk_state_t state_q, state_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = START;
        end else if (en) begin
            case (state_q)
                START:   state_d = is_op(in) ? ERR  : OPND;
                OPND:    state_d = is_op(in) ? OPER : ERR;
                OPER:    state_d = is_op(in) ? ERR  : OPND;
                default: state_d = ERR;
            endcase
        end
    end

    assign match = (state_q == OPND);

endmodule

// File: rtl/expr_stream_arbiter.sv
// Round-robin arbiter sharing one expr_checker between NUM_REQ byte-stream requesters.
// Optional EXPR_ARB_LEN_EN adds the res_len port and its saturating byte counter.
//
// state      | meaning
// CTL_IDLE   | no grant; pick next valid requester from rr_ptr, clear checker
// CTL_STREAM | granted requester streams bytes into the checker
// CTL_RESULT | result held on res_* until res_ready
module expr_stream_arbiter
    import expr_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_match
`ifdef EXPR_ARB_LEN_EN
    ,
    output logic [7:0]           res_len
`endif
);

    ctl_state_t      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            chk_clear, chk_en, chk_match;
    logic            cur_valid, cur_last;
    logic [7:0]      cur_byte;

    // Lowest offset from ptr wins, so scan offsets from the top down.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (v[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    assign cur_valid = req_valid[grant_q];
    assign cur_last  = req_last[grant_q];
    assign cur_byte  = req_data[{grant_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= CTL_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        chk_clear = 1'b0;
        chk_en    = 1'b0;
        req_ready = '0;
        res_valid = 1'b0;
        case (state_q)
            CTL_IDLE: begin
                if (|req_valid) begin
                    grant_d   = rr_pick(req_valid, rr_ptr_q);
                    chk_clear = 1'b1;
                    state_d   = CTL_STREAM;
                end
            end
            CTL_STREAM: begin
                req_ready = NUM_REQ'(1) << grant_q;
                if (cur_valid) begin
                    chk_en = 1'b1;
                    if (cur_last) state_d = CTL_RESULT;
                end
            end
            CTL_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    state_d  = CTL_IDLE;
                end
            end
            default: state_d = CTL_IDLE;
        endcase
    end

    expr_checker u_checker (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (chk_clear),
        .en    (chk_en),
        .in    (cur_byte),
        .match (chk_match)
    );

    assign res_id    = grant_q;
    // The checker keeps its last state while idle, so qualify match with res_valid.
    assign res_match = chk_match & res_valid;

`ifdef EXPR_ARB_LEN_EN
    logic [7:0] len_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            len_q <= '0;
        end else if (chk_clear) begin
            len_q <= '0;
        end else if (chk_en && (len_q != 8'hFF)) begin
            len_q <= len_q + 8'd1;
        end
    end

    assign res_len = len_q;
`endif

endmodule

// File: tb/tb_expr_stream_arbiter.sv
// Directed scoreboard bench for expr_stream_arbiter (NUM_REQ = 2).
module tb_expr_stream_arbiter;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [0:0]  res_id;
    logic        res_match;
`ifdef EXPR_ARB_LEN_EN
    logic [7:0]  res_len;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int id;
        int m;
        int len;
    } exp_t;
    exp_t sb[$];

    expr_stream_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_match (res_match)
`ifdef EXPR_ARB_LEN_EN
        ,
        .res_len   (res_len)
`endif
    );

    always #5 clk = ~clk;

    // Well-formed iff odd length, operands at even positions, operators at odd ones.
    function automatic int model_match(input string s);
        bit op;
        if (s.len() == 0) return 0;
        for (int i = 0; i < s.len(); i++) begin
            op = (s[i] == 8'h2A) || (s[i] == 8'h2B);
            if (op != ((i % 2) == 1)) return 0;
        end
        return (s.len() % 2 == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input string s);
        exp_t e;
        e.id  = id;
        e.m   = model_match(s);
        e.len = (s.len() > 255) ? 255 : s.len();
        sb.push_back(e);
    endtask

    task automatic send_str(input int id, input string s, input bit do_last,
                            input int bub_at, input int nbub);
        logic [1:0] other;
        bit         acc;
        int         cnt;
        other = ~(2'b01 << id);
        if (do_last) push_exp(id, s);
        for (int i = 0; i < s.len(); i++) begin
            if (i == bub_at) begin
                req_valid[id] = 1'b0;
                for (int b = 0; b < nbub; b++) begin
                    @(negedge clk);
                    chk("bubble_res_valid", 32'(res_valid), 0);
                    chk("bubble_other_ready", 32'(req_ready & other), 0);
                    @(posedge clk);
                    #1;
                end
            end
            req_valid[id]       = 1'b1;
            req_data[8*id +: 8] = s[i];
            req_last[id]        = do_last && (i == s.len() - 1);
            acc = 1'b0;
            cnt = 0;
            while (!acc && cnt < 50) begin
                @(negedge clk);
                chk("stream_res_valid", 32'(res_valid), 0);
                chk("stream_other_ready", 32'(req_ready & other), 0);
                acc = req_ready[id];
                @(posedge clk);
                #1;
                cnt++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $error("FAIL accept_timeout: observed no ready for req %0d byte %0d expected ready", id, i);
            end
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic wait_result(output int cycles);
        exp_t e;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!res_valid && cycles < 100);
        if (!res_valid) begin
            vectors++;
            miscompares++;
            $error("FAIL result_timeout: observed res_valid 0 expected 1");
        end else if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_result: observed result id %0d expected none", res_id);
        end else begin
            e = sb.pop_front();
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_match", 32'(res_match), 32'(e.m));
`ifdef EXPR_ARB_LEN_EN
            chk("res_len", 32'(res_len), 32'(e.len));
`endif
            if (res_ready) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_res_id"}, 32'(res_id), 0);
        chk({tag, "_res_match"}, 32'(res_match), 0);
`ifdef EXPR_ARB_LEN_EN
        chk({tag, "_res_len"}, 32'(res_len), 0);
`endif
    endtask

    initial begin
        int    cyc;
        string s;

        #1 clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        clr_n = 1'b1;

        // basic well-formed string, result one cycle after the last byte
        send_str(0, "3+4", 1, -1, 0);
        wait_result(cyc);
        chk("res_latency", 32'(cyc), 1);

        // malformed strings from requester 1
        send_str(1, "+5", 1, -1, 0);
        wait_result(cyc);
        send_str(1, "55", 1, -1, 0);
        wait_result(cyc);
        send_str(1, "5*", 1, -1, 0);
        wait_result(cyc);

        // both requesters valid from reset: single-byte strings alternate 0,1,0,1
        @(posedge clk);
        #1;
        clr_n     = 1'b0;
        req_valid = 2'b11;
        req_data  = 16'h2B35;
        req_last  = 2'b11;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        push_exp(0, "5");
        push_exp(1, "+");
        push_exp(0, "5");
        push_exp(1, "+");
        repeat (4) wait_result(cyc);
        req_valid = '0;
        req_last  = '0;

        // bubbles mid-string
        send_str(0, "7*2", 1, 1, 3);
        wait_result(cyc);

        // result backpressure holds everything
        res_ready = 1'b0;
        send_str(0, "6+1", 1, -1, 0);
        req_valid = 2'b11;
        req_data  = 16'h3939;
        req_last  = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 1);
            chk("bp_res_id", 32'(res_id), 0);
            chk("bp_res_match", 32'(res_match), 1);
            chk("bp_req_ready", 32'(req_ready), 0);
`ifdef EXPR_ARB_LEN_EN
            chk("bp_res_len", 32'(res_len), 3);
`endif
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        res_ready = 1'b1;
        wait_result(cyc);

        // reset mid-string discards the partial string
        send_str(0, "1+", 0, -1, 0);
        clr_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        send_str(0, "8*9", 1, -1, 0);
        wait_result(cyc);

        // long string: length saturates at 255
        s = "";
        for (int k = 0; k < 130; k++) s = {s, "5+"};
        s = {s, "5"};
        send_str(1, s, 1, -1, 0);
        wait_result(cyc);

        @(negedge clk);
        chk("final_res_valid", 32'(res_valid), 0);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/expr_stream_arbiter.md
# expr_stream_arbiter

Shares one expression checker between `NUM_REQ` byte-stream requesters. Each requester sends one string of 8-bit characters per transaction, with a last flag on the final byte. The block grants strings round-robin, clears and steps the checker for each accepted byte, and returns one tagged result per string. It sits between the character sources and the result consumer, and is the controller for the operand/operator recognizer datapath.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `ID_W`, default 1: width of the requester ID, equal to ceil(log2(`NUM_REQ`)).
- `clk` input, 1: the single clock; all state changes on the rising edge.
- `clr_n` input, 1: reset, asynchronous and active-low.
- `req_valid` input, `NUM_REQ`: one bit per requester; byte offered.
- `req_data` input, 8*`NUM_REQ`: byte of requester i is `req_data[8i+7:8i]`.
- `req_last` input, `NUM_REQ`: offered byte is the final byte of its string.
- `req_ready` output, `NUM_REQ`: byte of requester i is accepted when `req_valid[i]` and `req_ready[i]` are both high at a clock edge.
- `res_valid` output, 1: result available.
- `res_ready` input, 1: consumer accepts the result.
- `res_id` output, `ID_W`: requester whose string produced the result.
- `res_match` output, 1: the string is well-formed.
- `res_len` output, 8: accepted byte count, saturating at 255. Present only with `EXPR_ARB_LEN_EN`.

## Operation
- Operator bytes are 8'h2A (`*`) and 8'h2B (`+`). Every other byte value is an operand.
- A string is well-formed when it matches operand (operator operand)*.
- Checker states and transitions:
  - START: operator→ERR; operand→OPND.
  - OPND: operator→OPER; operand→ERR.
  - OPER: operator→ERR; operand→OPND.
  - ERR: stays in ERR.
  - `res_match` = 1 when the checker is in OPND after the last byte.
- Controller states:
  - IDLE: `req_ready` all 0. If any `req_valid` is high, grant the first valid requester found searching upward from `rr_ptr`, with wrap-around. Load `grant_id`, clear the checker to START, clear the length count, go to STREAM.
  - STREAM: `req_ready[grant_id]` = 1; all other ready bits are 0. Each accepted byte steps the checker and the length count. An accepted byte with `req_last` set moves to RESULT. A cycle with `req_valid[grant_id]` low is a bubble: no step, stay in STREAM.
  - RESULT: `res_valid` = 1, with `res_id`, `res_match` and `res_len` held stable. On `res_valid && res_ready`: set `rr_ptr` = `grant_id`+1 mod `NUM_REQ`, go to IDLE.
- Requesters that are not granted are only stalled; their bytes are never dropped.
- Reset values: state IDLE, checker START, `rr_ptr` 0. Outputs `req_ready` 0, `res_valid` 0, `res_id` 0, `res_match` 0, `res_len` 0.
- Reset asserted mid-string discards the partial string. No result is produced for it.

## Timing
- Grant latency: 1 cycle from IDLE with a valid request to STREAM.
- Throughput in STREAM: 1 byte per cycle.
- Result latency: `res_valid` rises 1 cycle after the edge that accepts the last byte.
- Per-string overhead: minimum n+2 cycles for an n-byte string, reached when `res_ready` is held high.
- `res_valid` stays high until the handshake completes. Backpressure on the result holds every requester.
- A string with `req_last` on its first byte is legal and has length 1.
- `res_len` saturates: a count of 255 followed by further bytes stays 255.

## Configuration
- `EXPR_ARB_LEN_EN` defined: the `res_len` port and the 8-bit saturating counter exist.
- `EXPR_ARB_LEN_EN` undefined: neither exists. All other behaviour is identical.

## Structure
- Package `expr_pkg`: checker state enum (START, OPND, OPER, ERR as a 2-bit encoding), and constants `OP_MUL` = 8'h2A and `OP_ADD` = 8'h2B.
- Sub-module `expr_checker`: ports `clk`, `clr_n`, `clear`, `en`, `in[7:0]`, `match`.
  - `clear` is synchronous and returns the checker to START.
  - `en` steps the checker by one byte.
  - `match` = 1 when the state is OPND.
- Top level: controller FSM, round-robin pointer, length counter.

## Test plan
- Req0 sends "3", "+", "4" (last on "4"), `res_ready` = 1 → `res_valid` 1 cycle after "4" is accepted, with `res_id` 0, `res_match` 1, `res_len` 3.
- Req1 sends "+", "5" → `res_match` 0. Req1 sends "5", "5" → `res_match` 0. Req1 sends "5", "*" → `res_match` 0.
- Req0 and req1 both valid from reset → grant order 0, 1, 0, 1 over four strings. Each string completes before the next grant.
- Req0 sends "7" then drops `req_valid` for 3 cycles, then sends "*", "2" → no result until "2" is accepted; `res_match` 1; `req_ready[1]` stays 0 throughout.
- `res_ready` held 0 for 5 cycles in RESULT → `res_valid`, `res_id` and `res_match` stable; no `req_ready` asserted.
- Reset pulsed while req0 is mid-string → all outputs return to reset values; the next string from req0 gives a fresh, correct result.
